// File: rtl/pipe_prefix_adder.sv
// pipe_prefix_adder: pipelined Kogge-Stone adder/subtractor with a sideband tag.
// One register stage holds the per-bit (g,p) pairs, one follows each of the
// LOG2W prefix levels, and a final stage holds S/C. The whole pipe advances
// together on one enable, so a stalled output freezes every stage.
// Optional feature: define PPA_OVF_EN to add the signed-overflow output ovf.
//
// Handshake: an operand set transfers on a rising edge with in_valid=1 and
// in_ready=1; a result transfers on a rising edge with out_valid=1 and
// out_ready=1. in_ready = !(out_valid & !out_ready), a combinational global
// stall, so results are never dropped or duplicated and stay stable while held.
module pipe_prefix_adder #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             C,
`ifdef PPA_OVF_EN
  output logic             ovf,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int LOG2W = $clog2(WIDTH);

  // Extended (g,p) vectors: index 0 is the virtual bit -1 carrying the
  // carry-in as its generate term (propagate 0); index i+1 is operand bit i.
  logic [WIDTH:0]   g_q   [0:LOG2W];
  logic [WIDTH:0]   pp_q  [0:LOG2W];
  logic [WIDTH-1:0] h_q   [0:LOG2W];   // half-sum A^B', needed for S at the end
  logic [TAG_W-1:0] tag_q [0:LOG2W];
  logic [LOG2W:0]   v_q;               // stage valid bits, bit k = stage k

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             ci_eff;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] s_fin;
  logic             c_fin;

  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;

  // Operand conditioning: subtraction is A + ~B + 1, cin ignored.
  always_comb begin
    b_eff  = sub ? ~B : B;
    ci_eff = sub ? 1'b1 : cin;
  end

  // After LOG2W levels extended position i (i < WIDTH) spans bit -1 up to bit
  // i-1, i.e. it is the carry into bit i. Position WIDTH only spans bits
  // 0..WIDTH-1, so the carry-out needs one last combine with the carry-in.
  always_comb begin
    carry = g_q[LOG2W][WIDTH-1:0];
    s_fin = h_q[LOG2W] ^ carry;
    c_fin = g_q[LOG2W][WIDTH] | (pp_q[LOG2W][WIDTH] & g_q[LOG2W][0]);
  end

  // Stage valid shift register; cleared asynchronously, frozen on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (en) begin
      v_q <= {v_q[LOG2W-1:0], in_valid};
    end
  end

  // Datapath stages: operand (g,p) capture, then one prefix level per stage.
  // Contents behind a cleared valid bit are don't-care, so no reset here.
  always_ff @(posedge clk) begin
    if (en) begin
      g_q[0]   <= {A & b_eff, ci_eff};
      pp_q[0]  <= {A ^ b_eff, 1'b0};
      h_q[0]   <= A ^ b_eff;
      tag_q[0] <= in_tag;
      for (int k = 1; k <= LOG2W; k++) begin
        // (g,p) o (g',p') with partner 2^(k-1) positions lower; positions
        // without a partner keep their pair (shift fills g'=0, p'=1).
        g_q[k]   <= g_q[k-1] | (pp_q[k-1] & (g_q[k-1] << (1 << (k-1))));
        pp_q[k]  <= pp_q[k-1] & ~((~pp_q[k-1]) << (1 << (k-1)));
        h_q[k]   <= h_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Output stage: loads only real results so S/C/out_tag hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      S         <= '0;
      C         <= 1'b0;
      out_tag   <= '0;
`ifdef PPA_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (en) begin
      out_valid <= v_q[LOG2W];
      if (v_q[LOG2W]) begin
        S       <= s_fin;
        C       <= c_fin;
        out_tag <= tag_q[LOG2W];
`ifdef PPA_OVF_EN
        ovf     <= carry[WIDTH-1] ^ c_fin;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipe_prefix_adder.sv
// Bench for pipe_prefix_adder: directed vector table, random traffic with
// random back-pressure checked against an arithmetic reference model, a
// mid-flight reset sequence, and latency checks at WIDTH 8, 32 and 64.
module tb_pipe_prefix_adder;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int EW = TW + 2 + W;   // {tag, ovf, C, S}
`ifdef PPA_OVF_EN
  localparam bit HAS_OVF = 1'b1;
`else
  localparam bit HAS_OVF = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- DUT, WIDTH=32 ----------------
  logic          in_valid, in_ready, cin, sub, out_valid, out_ready, c_o, ovf32;
  logic [W-1:0]  a, b, s_o;
  logic [TW-1:0] in_tag, out_tag;

  pipe_prefix_adder #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cin(cin), .sub(sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .S(s_o), .C(c_o),
`ifdef PPA_OVF_EN
    .ovf(ovf32),
`endif
    .out_tag(out_tag)
  );
`ifndef PPA_OVF_EN
  assign ovf32 = 1'b0;
`endif

  // ---------------- DUT, WIDTH=8 ----------------
  logic       iv8, ir8, ov8, ordy8, c8, ovf8;
  logic [7:0] a8, b8, s8;
  logic [3:0] t8, ot8;
  pipe_prefix_adder #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .cin(1'b0), .sub(1'b0), .in_tag(t8),
    .out_valid(ov8), .out_ready(ordy8), .S(s8), .C(c8),
`ifdef PPA_OVF_EN
    .ovf(ovf8),
`endif
    .out_tag(ot8)
  );
`ifndef PPA_OVF_EN
  assign ovf8 = 1'b0;
`endif

  // ---------------- DUT, WIDTH=64 ----------------
  logic        iv64, ir64, ov64, ordy64, c64, ovf64;
  logic [63:0] a64, b64, s64;
  logic [3:0]  t64, ot64;
  pipe_prefix_adder #(.WIDTH(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
    .A(a64), .B(b64), .cin(1'b0), .sub(1'b0), .in_tag(t64),
    .out_valid(ov64), .out_ready(ordy64), .S(s64), .C(c64),
`ifdef PPA_OVF_EN
    .ovf(ovf64),
`endif
    .out_tag(ot64)
  );
`ifndef PPA_OVF_EN
  assign ovf64 = 1'b0;
`endif

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain wide arithmetic, overflow from operand/result signs.
  function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mcin, input logic msub,
                                          input logic [TW-1:0] mtag);
    logic [W-1:0] bb;
    logic [W:0]   sum;
    logic         ov;
    bb  = msub ? ~mb : mb;
    sum = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, (msub ? 1'b1 : mcin)};
    ov  = (ma[W-1] == bb[W-1]) && (sum[W-1] != ma[W-1]);
    return {mtag, ov & HAS_OVF, sum[W], sum[W-1:0]};
  endfunction

  // ---------------- scoreboard / monitor (samples on falling edge) ----------
  logic [EW-1:0] exp_q[$];
  logic          held = 1'b0;
  logic [EW-1:0] held_v;
  logic [EW-1:0] obs;
  assign obs = {out_tag, ovf32, c_o, s_o};

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (held) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", obs, held_v);
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub, in_tag));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1'b1, 1'b0);
        end else begin
          chk("sb_result", obs, exp_q.pop_front());
        end
      end
      held   = out_valid && !out_ready;
      held_v = obs;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  // Single op into an empty pipe with out_ready=1; returns edges to out_valid.
  task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub, input logic [TW-1:0] ttag,
                         output int lat);
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_tag = ttag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); in_tag = 4'($urandom_range(0, 15));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic rand_op();
    a        = $urandom;
    b        = $urandom;
    cin      = 1'($urandom_range(0, 1));
    sub      = 1'($urandom_range(0, 1));
    in_tag   = 4'($urandom_range(0, 15));
    in_valid = ($urandom_range(0, 3) != 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic [TW-1:0] tag;
    logic [W-1:0]  s;
    logic          c;
    logic          ov;
  } vec_t;
  vec_t vt[11];

  initial begin
    int lat, issued, cyc, n;
    logic acc;

    vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd3,  32'h00000000, 1'b1, 1'b0};
    vt[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 4'd1,  32'hFFFFFFFE, 1'b0, 1'b0};
    vt[2]  = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 4'd2,  32'h00000002, 1'b1, 1'b0};
    vt[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 4'd4,  32'h80000000, 1'b0, 1'b1};
    vt[4]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 4'd5,  32'h7FFFFFFF, 1'b1, 1'b1};
    vt[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 4'd6,  32'h00000001, 1'b0, 1'b0};
    vt[6]  = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 4'd7,  32'h2345678A, 1'b0, 1'b0};
    vt[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 4'd8,  32'h00000000, 1'b1, 1'b0};
    vt[8]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 4'd9,  32'h00000007, 1'b1, 1'b0};
    vt[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'd10, 32'h00000000, 1'b1, 1'b1};
    vt[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 4'd15, 32'hFFFFFFFF, 1'b1, 1'b0};

    // ---- reset ----
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_tag = '0; out_ready = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; t8 = '0; ordy8 = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0; t64 = '0; ordy64 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_S", s_o, 32'h0);
    chk("rst_C", c_o, 1'b0);
    chk("rst_out_tag", out_tag, 4'h0);
    chk("rst_ovf", ovf32, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- directed table ----
    for (int i = 0; i < 11; i++) begin
      run_one(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].tag, lat);
      chk($sformatf("vec%0d_latency", i), lat, 6);
      chk($sformatf("vec%0d_S", i), s_o, vt[i].s);
      chk($sformatf("vec%0d_C", i), c_o, vt[i].c);
      chk($sformatf("vec%0d_tag", i), out_tag, vt[i].tag);
      if (HAS_OVF) chk($sformatf("vec%0d_ovf", i), ovf32, vt[i].ov);
    end
    repeat (3) @(posedge clk);
    #1;

    // ---- random traffic with back-pressure ----
    issued = 0; cyc = 0;
    out_ready = 1'b0;
    rand_op();
    while (issued < 40 && cyc < 2000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) issued++;
      if (acc || !in_valid) rand_op();
      else begin
        // held op keeps its data; idle cycles still scramble inputs below
      end
      out_ready = ((cyc % 16) < 6) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    chk("random_issued", issued, 40);
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("random_drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;

    // ---- reset with operations in flight ----
    for (int j = 0; j < 3; j++) begin
      a = $urandom; b = $urandom; cin = 1'b0; sub = 1'($urandom_range(0, 1));
      in_tag = 4'(j + 1); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      chk("midrst_flushed", out_valid, 1'b0);
    end
    run_one(32'h00001000, 32'h00000234, 1'b1, 1'b0, 4'd12, lat);
    chk("postrst_latency", lat, 6);
    chk("postrst_S", s_o, 32'h00001235);
    chk("postrst_C", c_o, 1'b0);
    chk("postrst_tag", out_tag, 4'd12);
    repeat (2) @(posedge clk);
    #1;

    // ---- WIDTH=8 ----
    a8 = 8'hFF; b8 = 8'h01; t8 = 4'd3; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_latency", lat, 4);
    chk("w8_S", s8, 8'h00);
    chk("w8_C", c8, 1'b1);
    chk("w8_tag", ot8, 4'd3);
    chk("w8_in_ready", ir8, 1'b1);

    // ---- WIDTH=64 ----
    a64 = 64'hFFFFFFFF_FFFFFFFF; b64 = 64'h1; t64 = 4'd3; iv64 = 1'b1;
    @(posedge clk); #1;
    iv64 = 1'b0; a64 = 64'h0123456789ABCDEF; b64 = 64'h0;
    lat = 0;
    while (!ov64 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w64_latency", lat, 7);
    chk("w64_S", s64, 64'h0);
    chk("w64_C", c64, 1'b1);
    chk("w64_tag", ot64, 4'd3);
    if (HAS_OVF) begin
      chk("w8_ovf", ovf8, 1'b0);
      chk("w64_ovf", ovf64, 1'b0);
    end
    chk("w64_in_ready", ir64, 1'b1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
